bus2_arbiter: RTL and testbench
===============================

Name: bus2_arbiter

Overview:
Arbitrates two requesters, A and B, for the shared WIDTH-bit 2:1 mux datapath. Drives the mux select and moves the winner's data into a registered output stage with a valid/ready handshake. Round-robin with a bounded burst, so one requester cannot starve the other. Sits in front of the 8-bit two-input mux (8 x 1-bit mux slices) and owns its select line.

Parameters:
WIDTH, 8, data width of each requester and the output bus
MAX_BURST, 4, max consecutive beats granted to one requester while the other is waiting (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_a  input  1  requester A has a beat on data_a; held until ack_a
data_a  input  WIDTH  requester A data
ack_a  output  1  beat from A accepted this cycle (combinational, single-cycle pulse per beat)
req_b  input  1  requester B has a beat on data_b
data_b  input  WIDTH  requester B data
ack_b  output  1  beat from B accepted this cycle
sel  output  1  mux select, registered; 0 = A, 1 = B
out_data  output  WIDTH  registered output beat
out_valid  output  1  out_data holds an untaken beat
out_ready  input  1  downstream accepts out_data when out_valid=1

Behaviour:
- Single clock. rst_n is asynchronous active-low and applies immediately.
- Reset values: state=IDLE, sel=0, out_data=0, out_valid=0, ack_a=ack_b=0, burst_cnt=0, last_served=B (A wins the first tie).
- load = !out_valid || out_ready. This is the output register's free or draining condition.
- FSM states: IDLE, GNT_A, GNT_B. The state register drives sel: GNT_A sets sel=0, GNT_B sets sel=1, IDLE holds the last sel.
- IDLE:
  - Only req_a -> GNT_A. Only req_b -> GNT_B.
  - Both -> grant the requester != last_served.
  - No beat is transferred in IDLE; there is 1 cycle of grant latency.
- GNT_x, beat condition: a beat occurs when req_x && load.
  - ack_x=1 in that cycle.
  - Next edge: out_data<=data_x, out_valid<=1, burst_cnt++, last_served<=x.
- out_valid clears on out_ready when no new beat loads in the same cycle.
- Simultaneous out_ready and a new beat: the new beat replaces the old one, out_valid stays 1, and no bubble is inserted.
- Leaving GNT_x:
  - req_x low and other req high -> GNT_other, burst_cnt=0.
  - req_x low and other req low -> IDLE, burst_cnt=0.
  - A beat makes burst_cnt reach MAX_BURST and the other req is high -> GNT_other, burst_cnt=0.
  - A beat makes burst_cnt reach MAX_BURST and the other req is low -> stay in GNT_x, burst_cnt=0.
- Switch is direct GNT_A<->GNT_B with no IDLE cycle. The new grantee can get a beat in the cycle right after the switch.
- Backpressure (out_valid=1, out_ready=0):
  - No ack and no beat.
  - out_data is stable and the state holds.
  - Burst expiry is not evaluated.
- ack_a and ack_b are never high in the same cycle. ack_x is high only when sel==x.
- Reset mid-burst:
  - Outputs return to reset values asynchronously and the in-flight beat is dropped.
  - A requester still asserting req after reset is re-arbitrated from IDLE.
- burst_cnt width is clog2(MAX_BURST+1).
- MAX_BURST=1 gives pure beat-by-beat alternation under contention.

Optional Feature:
Macro: BUS2_ARB_PRIO_A_EN.
- Defined:
  - Fixed priority: A wins every tie in IDLE.
  - In GNT_A the burst counter is ignored and A keeps the grant while req_a is high.
  - In GNT_B, if req_a is high, the arbiter switches to GNT_A at burst expiry, or when req_b drops.
  - last_served is unused.
- Undefined: round-robin as described above.

Test Plan:
1. Assert rst_n=0 for 2 cycles with random inputs -> sel=0, out_valid=0, out_data=0, ack_a=ack_b=0. Release -> IDLE.
2. Only req_a=1, data_a=8'd4, out_ready=1 -> cycle 1 enters GNT_A with sel=0; cycle 2 ack_a=1; cycle 3 out_data=8'h04, out_valid=1. Continuous beats are 1 per cycle.
3. req_a=req_b=1 held, data_a=8'd4, data_b=8'd7, MAX_BURST=4, out_ready=1 -> out_data sequence 4,4,4,4,7,7,7,7,4,...; sel toggles every 4 beats with no dead cycle at the switch.
4. In GNT_A with out_valid=1, hold out_ready=0 for 3 cycles -> ack_a=0, out_data stays 8'h04, burst_cnt is frozen. Raise out_ready -> the next beat loads that same cycle with no bubble.
5. Pull rst_n low mid-burst (burst_cnt=2, sel=1) -> out_valid=0 and sel=0 immediately. After release with req_a=req_b=1 -> A is granted first.
6. With BUS2_ARB_PRIO_A_EN defined, req_a=req_b=1 held -> only data_a beats (8'h04) and ack_b never pulses. Drop req_a -> B is granted within 1 cycle, out_data=8'h07.

Source files
------------

// File: rtl/bus2_arbiter.sv
// Two-requester arbiter that owns the 2:1 mux select and registers the winning beat behind a valid/ready output.
// Round-robin with a bounded burst by default; define BUS2_ARB_PRIO_A_EN for fixed priority to requester A.
module bus2_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_a,
    input  logic [WIDTH-1:0] data_a,
    output logic             ack_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_b,
    output logic             ack_b,
    output logic             sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] burst_cnt, cnt_nxt;
    logic          load;
`ifndef BUS2_ARB_PRIO_A_EN
    logic          last_served;  // 0 = A, 1 = B
`endif

    // Output register is empty or being drained this cycle
    assign load = !out_valid || out_ready;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = burst_cnt;
        ack_a     = 1'b0;
        ack_b     = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
`ifdef BUS2_ARB_PRIO_A_EN
                if (req_a)      state_nxt = GNT_A;
                else if (req_b) state_nxt = GNT_B;
`else
                if (req_a && req_b) state_nxt = last_served ? GNT_A : GNT_B;
                else if (req_a)     state_nxt = GNT_A;
                else if (req_b)     state_nxt = GNT_B;
`endif
            end
            GNT_A: begin
                ack_a = req_a && load;
                if (!req_a) begin
                    state_nxt = req_b ? GNT_B : IDLE;
                    cnt_nxt   = '0;
                end else if (load) begin
`ifdef BUS2_ARB_PRIO_A_EN
                    cnt_nxt = '0;
`else
                    if (burst_cnt == LAST_BEAT) begin
                        cnt_nxt = '0;
                        if (req_b) state_nxt = GNT_B;
                    end else begin
                        cnt_nxt = burst_cnt + CW'(1);
                    end
`endif
                end
            end
            GNT_B: begin
                ack_b = req_b && load;
                if (!req_b) begin
                    state_nxt = req_a ? GNT_A : IDLE;
                    cnt_nxt   = '0;
                end else if (load) begin
                    if (burst_cnt == LAST_BEAT) begin
                        cnt_nxt = '0;
                        if (req_a) state_nxt = GNT_A;
                    end else begin
                        cnt_nxt = burst_cnt + CW'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            burst_cnt <= '0;
            sel       <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
`ifndef BUS2_ARB_PRIO_A_EN
            last_served <= 1'b1;
`endif
        end else begin
            state     <= state_nxt;
            burst_cnt <= cnt_nxt;
            // sel follows the grant state; IDLE keeps the previous select
            if (state_nxt == GNT_A)      sel <= 1'b0;
            else if (state_nxt == GNT_B) sel <= 1'b1;
            if (ack_a) begin
                out_data  <= data_a;
                out_valid <= 1'b1;
`ifndef BUS2_ARB_PRIO_A_EN
                last_served <= 1'b0;
`endif
            end else if (ack_b) begin
                out_data  <= data_b;
                out_valid <= 1'b1;
`ifndef BUS2_ARB_PRIO_A_EN
                last_served <= 1'b1;
`endif
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bus2_arbiter.sv
// Directed self-checking bench for bus2_arbiter (WIDTH=8, MAX_BURST=4).
module tb_bus2_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_a, req_b, out_ready;
    logic [7:0] data_a, data_b;
    logic       ack_a, ack_b, sel, out_valid;
    logic [7:0] out_data;

    int n_chk  = 0;
    int n_pass = 0;

    bus2_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_a     (req_a),
        .data_a    (data_a),
        .ack_a     (ack_a),
        .req_b     (req_b),
        .data_b    (data_b),
        .ack_b     (ack_b),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst_n     = 1'b0;
        req_a     = 1'($urandom);
        req_b     = 1'($urandom);
        data_a    = 8'($urandom);
        data_b    = 8'($urandom);
        out_ready = 1'($urandom);
        repeat (cycles) @(posedge clk);
        #1;
        req_a     = 1'b0;
        req_b     = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        #1;
    endtask

    logic [7:0] exp_data [9] = '{8'd4, 8'd4, 8'd4, 8'd4, 8'd7, 8'd7, 8'd7, 8'd7, 8'd4};
    logic       exp_sel  [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        // Reset
        rst_n = 1'b0;
        do_reset(2);
        chk("rst_sel", sel, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ack_a", ack_a, 0);
        chk("rst_ack_b", ack_b, 0);

        // Single requester A
        req_a  = 1'b1;
        data_a = 8'd4;
        #1;
        chk("idle_no_ack", ack_a, 0);
        step();
        chk("t2_sel", sel, 0);
        chk("t2_ack_a", ack_a, 1);
        chk("t2_valid0", out_valid, 0);
        step();
        chk("t2_data", out_data, 8'h04);
        chk("t2_valid1", out_valid, 1);
        chk("t2_cont_ack", ack_a, 1);
        req_a = 1'b0;
        #1;
        step();
        chk("t2_drain", out_valid, 0);

`ifndef BUS2_ARB_PRIO_A_EN
        // Contention, bursts of 4
        do_reset(1);
        req_a  = 1'b1;
        req_b  = 1'b1;
        data_a = 8'd4;
        data_b = 8'd7;
        step();
        chk("t3_first_ack_a", ack_a, 1);
        for (int i = 0; i < 9; i++) begin
            step();
            chk($sformatf("t3_data%0d", i), out_data, exp_data[i]);
            chk($sformatf("t3_sel%0d", i), sel, exp_sel[i]);
            chk($sformatf("t3_valid%0d", i), out_valid, 1);
            chk($sformatf("t3_ack_excl%0d", i), ack_a & ack_b, 0);
        end

        // Backpressure in GNT_A with burst_cnt=1
        req_b     = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("t4_stall_ack", ack_a, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("t4_hold_data%0d", i), out_data, 8'h04);
            chk($sformatf("t4_hold_valid%0d", i), out_valid, 1);
            chk($sformatf("t4_hold_ack%0d", i), ack_a, 0);
        end
        req_b     = 1'b1;
        out_ready = 1'b1;
        data_a    = 8'd5;
        #1;
        chk("t4_release_ack", ack_a, 1);
        step();
        chk("t4_no_bubble", out_data, 8'h05);
        chk("t4_sel_a1", sel, 0);
        step();
        chk("t4_sel_a2", sel, 0);
        step();
        chk("t4_switch_b", sel, 1);

        // Reset mid-burst in GNT_B
        step();
        step();
        chk("t5_pre_sel", sel, 1);
        chk("t5_pre_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_async_valid", out_valid, 0);
        chk("t5_async_sel", sel, 0);
        chk("t5_async_data", out_data, 0);
        chk("t5_async_ack_b", ack_b, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("t5_idle_ack", ack_a, 0);
        step();
        chk("t5_grant_a_sel", sel, 0);
        chk("t5_grant_a_ack", ack_a, 1);
        chk("t5_grant_b_ack", ack_b, 0);
        step();
        chk("t5_data", out_data, 8'h05);
`else
        // Fixed priority to A
        do_reset(1);
        req_a  = 1'b1;
        req_b  = 1'b1;
        data_a = 8'd4;
        data_b = 8'd7;
        step();
        chk("p_sel_a", sel, 0);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("p_no_ack_b%0d", i), ack_b, 0);
            step();
            chk($sformatf("p_data%0d", i), out_data, 8'h04);
        end
        req_a = 1'b0;
        #1;
        step();
        chk("p_sel_b", sel, 1);
        chk("p_ack_b", ack_b, 1);
        step();
        chk("p_data_b", out_data, 8'h07);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
